// File: rtl/xgmii2gmii_tx.sv
// xgmii2gmii_tx
//  Transmit-direction width converter. Takes XGMII-coded 64-bit words
//  (8 data lanes + 8 control flags, lane 0 = first byte) from the read side
//  of an upstream FIFO and serialises them onto an 8-bit GMII transmit
//  interface, one byte per gmii_clk. The XGMII start (FB), terminate (FD)
//  and idle (07) characters are removed. The start character is replaced by
//  a preamble byte (8'h55), and the rest of the preamble and the SFD pass
//  through unchanged. The block enforces the inter-frame gap and marks frames
//  that are malformed, underrun or too long.
//
//  Ports
//   gmii_clk     in   1   sole clock
//   sys_rst_n    in   1   asynchronous active-low reset
//   xgmii_valid  in   1   upstream word available (FIFO not empty)
//   xgmii_ready  out  1   word consumed this cycle (combinational)
//   xgmii_txc    in   8   per-lane control flags
//   xgmii_txd    in   64  lane data, lane n = bits [8n+7:8n]
//   gmii_tx_en   out  1   GMII transmit enable (registered)
//   gmii_tx_er   out  1   GMII transmit error (registered)
//   gmii_txd     out  8   GMII transmit byte (registered)
module xgmii2gmii_tx #(
    parameter int FRAME_MAX_BIT_WIDTH = 11,
    parameter int IFG_BYTES           = 12
) (
    input  logic        gmii_clk,
    input  logic        sys_rst_n,
    input  logic        xgmii_valid,
    output logic        xgmii_ready,
    input  logic [7:0]  xgmii_txc,
    input  logic [63:0] xgmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic [7:0]  gmii_txd
);

    localparam logic [7:0] XG_START = 8'hFB;
    localparam logic [7:0] XG_TERM  = 8'hFD;
    localparam logic [7:0] PREAMBLE = 8'h55;
    localparam int IFG_W = $clog2(IFG_BYTES + 1);
    localparam logic [FRAME_MAX_BIT_WIDTH-1:0] CNT_ONE  = FRAME_MAX_BIT_WIDTH'(1);
    // When the counter holds this value, the byte about to be driven is the
    // last byte that fits (2**W-1).
    localparam logic [FRAME_MAX_BIT_WIDTH-1:0] CNT_LAST =
        FRAME_MAX_BIT_WIDTH'((1 << FRAME_MAX_BIT_WIDTH) - 2);

    typedef enum logic [1:0] {IDLE, SEND, DROP, IFG} state_t;

    state_t                         state_reg;
    logic [7:0]                     hold_c_reg;
    logic [63:0]                    hold_d_reg;
    logic [2:0]                     byte_idx_reg;
    logic [FRAME_MAX_BIT_WIDTH-1:0] byte_cnt_reg;
    logic [IFG_W-1:0]               ifg_cnt_reg;

    logic [7:0] hold_lane [8];
    logic [7:0] hold_fd;
    logic [7:0] in_fd;

    // Per-lane views of the held word and the incoming word.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign hold_lane[gi] = hold_d_reg[8*gi +: 8];
            assign hold_fd[gi]   = hold_c_reg[gi] && (hold_d_reg[8*gi +: 8] == XG_TERM);
            assign in_fd[gi]     = xgmii_txc[gi] && (xgmii_txd[8*gi +: 8] == XG_TERM);
        end
    endgenerate

    logic       cur_c;
    logic [7:0] cur_d;
    logic       cur_fd;
    logic       last_lane;
    logic       trunc;
    logic       underrun;
    logic       rem_fd;
    logic       is_start;
    logic       ifg_done;

    assign cur_c     = hold_c_reg[byte_idx_reg];
    assign cur_d     = hold_lane[byte_idx_reg];
    assign cur_fd    = hold_fd[byte_idx_reg];
    assign last_lane = (byte_idx_reg == 3'd7);
    assign trunc     = (byte_cnt_reg == CNT_LAST);
    assign underrun  = last_lane && !xgmii_valid;
    // A terminate character later in the held word means that the frame
    // ends inside this word. A truncated frame then goes straight to the gap
    // and does not consume (and lose) the next frame's start word.
    assign rem_fd    = |(hold_fd >> ({1'b0, byte_idx_reg} + 4'd1));
    assign is_start  = (xgmii_txc == 8'h01) && (xgmii_txd[7:0] == XG_START);
    assign ifg_done  = (int'(ifg_cnt_reg) + 2 >= IFG_BYTES);

    // The next word is taken only while lane 7 is being driven, and only if
    // the frame goes on past lane 7. This keeps back-to-back words gap-free.
    always_comb begin
        xgmii_ready = 1'b0;
        case (state_reg)
            IDLE:    xgmii_ready = 1'b1;
            SEND:    xgmii_ready = last_lane && !cur_fd && !trunc;
            DROP:    xgmii_ready = 1'b1;
            default: xgmii_ready = 1'b0;
        endcase
    end

    always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg    <= IDLE;
            hold_c_reg   <= '0;
            hold_d_reg   <= '0;
            byte_idx_reg <= '0;
            byte_cnt_reg <= '0;
            ifg_cnt_reg  <= '0;
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
            gmii_txd     <= '0;
        end else begin
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            gmii_txd   <= '0;
            case (state_reg)
                IDLE: begin
                    if (xgmii_valid && is_start) begin
                        // Lane 0 (the start character) is sent as preamble
                        // in the same cycle, to meet one-cycle latency. So
                        // the lane index and byte count resume at 1.
                        hold_c_reg   <= xgmii_txc;
                        hold_d_reg   <= xgmii_txd;
                        byte_idx_reg <= 3'd1;
                        byte_cnt_reg <= CNT_ONE;
                        gmii_tx_en   <= 1'b1;
                        gmii_txd     <= PREAMBLE;
                        state_reg    <= SEND;
                    end
                end
                SEND: begin
                    if (cur_fd) begin
                        state_reg   <= IFG;
                        ifg_cnt_reg <= '0;
                    end else begin
                        gmii_tx_en   <= 1'b1;
                        gmii_txd     <= cur_d;
                        gmii_tx_er   <= cur_c || trunc || underrun;
                        byte_idx_reg <= byte_idx_reg + 3'd1;
                        byte_cnt_reg <= byte_cnt_reg + CNT_ONE;
                        if (trunc) begin
                            byte_cnt_reg <= '0;
                            ifg_cnt_reg  <= '0;
                            state_reg    <= rem_fd ? IFG : DROP;
                        end else if (last_lane) begin
                            if (xgmii_valid) begin
                                hold_c_reg <= xgmii_txc;
                                hold_d_reg <= xgmii_txd;
                            end else begin
                                byte_cnt_reg <= '0;
                                state_reg    <= DROP;
                            end
                        end
                    end
                end
                DROP: begin
                    if (xgmii_valid && |in_fd) begin
                        state_reg   <= IFG;
                        ifg_cnt_reg <= '0;
                    end
                end
                IFG: begin
                    // The first IFG cycle is already an idle byte on the line.
                    // Leaving after IFG_BYTES-1 cycles lets the next start
                    // word be taken so that its first byte follows exactly
                    // IFG_BYTES idle bytes.
                    if (ifg_done) begin
                        state_reg <= IDLE;
                    end else begin
                        ifg_cnt_reg <= ifg_cnt_reg + IFG_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xgmii2gmii_tx.sv
// Self-checking bench for xgmii2gmii_tx.
//  Frames are built at byte level. The expected GMII bytes and frame lengths
//  are pushed to scoreboard queues when a frame is queued for the feeder. A
//  monitor pops and compares them as the selected DUT transmits. Two
//  instances are used: u_dut (default counter width) and u_dut_trunc (6-bit
//  counter, used for truncation). A select signal routes the stimulus to one
//  of them.
module tb_xgmii2gmii_tx;

    localparam int IFG         = 12;
    localparam int TRUNC_BYTES = 63;

    typedef struct packed {
        logic        gap;
        logic [7:0]  c;
        logic [63:0] d;
    } word_t;

    logic        gmii_clk = 1'b0;
    logic        sys_rst_n;
    logic        valid;
    logic [7:0]  txc;
    logic [63:0] txd;
    logic        sel;

    logic        ready_a, en_a, er_a;
    logic [7:0]  gtxd_a;
    logic        ready_b, en_b, er_b;
    logic [7:0]  gtxd_b;

    logic        m_ready, m_en, m_er;
    logic [7:0]  m_txd;

    word_t       wq[$];
    logic [8:0]  exp_q[$];
    int          len_q[$];
    int          st_q[$];

    int          cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    bit          mon_en = 1'b0;

    always #5 gmii_clk = ~gmii_clk;
    always @(posedge gmii_clk) cyc <= cyc + 1;

    xgmii2gmii_tx #(.FRAME_MAX_BIT_WIDTH(11), .IFG_BYTES(IFG)) u_dut (
        .gmii_clk    (gmii_clk),
        .sys_rst_n   (sys_rst_n),
        .xgmii_valid (valid && !sel),
        .xgmii_ready (ready_a),
        .xgmii_txc   (txc),
        .xgmii_txd   (txd),
        .gmii_tx_en  (en_a),
        .gmii_tx_er  (er_a),
        .gmii_txd    (gtxd_a)
    );

    xgmii2gmii_tx #(.FRAME_MAX_BIT_WIDTH(6), .IFG_BYTES(IFG)) u_dut_trunc (
        .gmii_clk    (gmii_clk),
        .sys_rst_n   (sys_rst_n),
        .xgmii_valid (valid && sel),
        .xgmii_ready (ready_b),
        .xgmii_txc   (txc),
        .xgmii_txd   (txd),
        .gmii_tx_en  (en_b),
        .gmii_tx_er  (er_b),
        .gmii_txd    (gtxd_b)
    );

    assign m_ready = sel ? ready_b : ready_a;
    assign m_en    = sel ? en_b    : en_a;
    assign m_er    = sel ? er_b    : er_a;
    assign m_txd   = sel ? gtxd_b  : gtxd_a;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [7:0] c, input logic [63:0] d);
        word_t w;
        w.gap = 1'b0;
        w.c   = c;
        w.d   = d;
        wq.push_back(w);
    endtask

    // Builds a frame: start + six 55 + D5 + payload, then FD and 07 padding.
    // err_at   : payload index replaced by a control FE (-1 = none)
    // ur_word  : valid drops for 3 cycles after this word (-1 = none)
    // trunc    : expect truncation at TRUNC_BYTES (only for u_dut_trunc)
    task automatic build_frame(input int plen, input int err_at, input int ur_word, input bit trunc);
        logic [8:0] ln[$];
        logic [8:0] e;
        int         cut;
        bit         abort;
        word_t      w;
        ln.push_back({1'b1, 8'hFB});
        for (int i = 0; i < 6; i++) ln.push_back({1'b0, 8'h55});
        ln.push_back({1'b0, 8'hD5});
        for (int i = 0; i < plen; i++) begin
            if (i == err_at) ln.push_back({1'b1, 8'hFE});
            else             ln.push_back({1'b0, 8'($urandom_range(0, 255))});
        end
        cut   = ln.size();
        abort = 1'b0;
        if (ur_word >= 0 && 8 * (ur_word + 1) < cut) begin
            cut   = 8 * (ur_word + 1);
            abort = 1'b1;
        end
        if (trunc && TRUNC_BYTES < cut) begin
            cut   = TRUNC_BYTES;
            abort = 1'b1;
        end
        for (int j = 0; j < cut; j++) begin
            e = (j == 0) ? {1'b0, 8'h55} : ln[j];
            if (abort && j == cut - 1) e[8] = 1'b1;
            exp_q.push_back(e);
        end
        len_q.push_back(cut);
        ln.push_back({1'b1, 8'hFD});
        while (ln.size() % 8 != 0) ln.push_back({1'b1, 8'h07});
        for (int wi = 0; wi < ln.size() / 8; wi++) begin
            w.gap = 1'b0;
            for (int k = 0; k < 8; k++) begin
                w.c[k]        = ln[8*wi+k][8];
                w.d[8*k +: 8] = ln[8*wi+k][7:0];
            end
            wq.push_back(w);
            if (wi == ur_word) begin
                w.gap = 1'b1;
                repeat (3) wq.push_back(w);
            end
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((wq.size() != 0 || exp_q.size() != 0 || len_q.size() != 0 || m_en) && k < 3000) begin
            @(negedge gmii_clk);
            k++;
        end
        chk("pending_words", 64'(wq.size()), 64'd0);
        chk("pending_bytes", 64'(exp_q.size() + len_q.size()), 64'd0);
        repeat (16) @(negedge gmii_clk);
    endtask

    // Feeder. A gap entry holds valid low until the DUT asks for a word,
    // so it always lands where an underrun can be seen.
    initial begin
        bit fire;
        bit is_start;
        valid = 1'b0;
        txc   = 8'hFF;
        txd   = {8{8'h07}};
        forever begin
            @(negedge gmii_clk);
            if (wq.size() > 0 && !wq[0].gap) begin
                valid = 1'b1;
                txc   = wq[0].c;
                txd   = wq[0].d;
            end else begin
                valid = 1'b0;
                txc   = 8'hFF;
                txd   = {8{8'h07}};
            end
            #1;
            fire     = 1'b0;
            is_start = 1'b0;
            if (wq.size() > 0) begin
                fire     = wq[0].gap ? m_ready : (valid && m_ready);
                is_start = !wq[0].gap && wq[0].c == 8'h01 && wq[0].d[7:0] == 8'hFB;
            end
            @(posedge gmii_clk);
            if (fire && wq.size() > 0) begin
                if (is_start) st_q.push_back(cyc);
                wq.delete(0);
            end
        end
    end

    // Monitor.
    int prev_en = 0;
    int idle    = 1000;
    int run     = 0;
    always @(negedge gmii_clk) begin
        if (!mon_en) begin
            prev_en = 0;
            idle    = 1000;
            run     = 0;
        end else begin
            if (m_en) begin
                if (prev_en == 0) begin
                    chk("ifg_gap_ok", 64'(idle >= IFG), 64'd1);
                    if (st_q.size() > 0) chk("start_latency", 64'(cyc), 64'(st_q.pop_front() + 1));
                    else                 chk("start_unexpected", 64'(m_en), 64'd0);
                    run = 0;
                end
                run++;
                if (exp_q.size() > 0) chk("byte", {55'd0, m_er, m_txd}, {55'd0, exp_q.pop_front()});
                else                  chk("extra_byte", 64'(m_en), 64'd0);
            end else begin
                if (prev_en != 0) begin
                    if (len_q.size() > 0) chk("frame_len", 64'(run), 64'(len_q.pop_front()));
                    else                  chk("frame_len_unexpected", 64'(run), 64'd0);
                    chk("idle_er_txd", {55'd0, m_er, m_txd}, 64'd0);
                    idle = 0;
                end
                idle++;
            end
            prev_en = m_en ? 1 : 0;
        end
    end

    initial begin
        sys_rst_n = 1'b1;
        sel       = 1'b0;
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst_tx_en",       64'(en_a),    64'd0);
        chk("rst_tx_er",       64'(er_a),    64'd0);
        chk("rst_txd",         64'(gtxd_a),  64'd0);
        chk("rst_ready_idle",  64'(ready_a), 64'd1);
        chk("rst_trunc_tx_en", 64'(en_b),    64'd0);
        chk("rst_trunc_txd",   64'(gtxd_b),  64'd0);
        repeat (3) @(negedge gmii_clk);
        sys_rst_n = 1'b1;
        mon_en    = 1'b1;

        // 1: idles, then a 72-byte frame ending on a word boundary.
        // 2: FD in lane 4, followed back-to-back by another frame (exact IFG).
        push_word(8'hFF, {8{8'h07}});
        push_word(8'hFF, {8{8'h07}});
        build_frame(64, -1, -1, 1'b0);
        build_frame(68, -1, -1, 1'b0);
        build_frame(20, -1, -1, 1'b0);
        wait_drain();

        // 3: underrun after the third word, then a clean frame.
        build_frame(40, -1, 2, 1'b0);
        build_frame(16, -1, -1, 1'b0);
        wait_drain();

        // 4: control FE in place of a data byte.
        build_frame(30, 5, -1, 1'b0);
        push_word(8'h00, 64'h0123_4567_89AB_CDEF);   // stray data in IDLE
        build_frame(9, -1, -1, 1'b0);
        wait_drain();

        // 5: 80-byte frame into the 6-bit counter instance.
        @(negedge gmii_clk);
        sel = 1'b1;
        build_frame(72, -1, -1, 1'b1);
        build_frame(20, -1, -1, 1'b0);
        wait_drain();
        @(negedge gmii_clk);
        sel = 1'b0;

        // 6: reset mid-frame, then idles and a clean frame.
        build_frame(64, -1, -1, 1'b0);
        begin
            int k;
            k = 0;
            while (exp_q.size() >= 40 && k < 500) begin
                @(negedge gmii_clk);
                k++;
            end
            chk("midframe_reached", 64'(exp_q.size() < 40), 64'd1);
        end
        @(posedge gmii_clk);
        #3;
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_tx_en", 64'(en_a),   64'd0);
        chk("midrst_tx_er", 64'(er_a),   64'd0);
        chk("midrst_txd",   64'(gtxd_a), 64'd0);
        mon_en = 1'b0;
        wq.delete();
        exp_q.delete();
        len_q.delete();
        st_q.delete();
        repeat (2) @(negedge gmii_clk);
        sys_rst_n = 1'b1;
        mon_en    = 1'b1;
        repeat (4) push_word(8'hFF, {8{8'h07}});
        push_word(8'h00, 64'hDEAD_BEEF_0000_1111);
        repeat (10) @(negedge gmii_clk);
        chk("post_rst_idle", 64'(en_a), 64'd0);
        build_frame(16, -1, -1, 1'b0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
